// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC and feeding the IF/ID register
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   imem_req_valid/ready/addr       single-outstanding fetch request channel (addr = pc)
//   imem_resp_valid/instr           valid-only response, one per accepted request
//   stall_id, redirect_valid/pc     hazard hold and EX branch/jump redirect
//   ifid_we, ifid_flush             IF/ID write enable and clear (flush dominates)
//   if_instr/pc/pc_plus4/valid      IF/ID data; if_valid=0 marks a NOP bubble
module fetch_ctrl #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_instr,
  input  logic            stall_id,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            if_valid
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] pc, pc_n, req_pc, req_pc_n;
  logic [ILEN-1:0] hold_instr, hold_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_pc <= '0;
      hold_instr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      req_pc <= req_pc_n;
      hold_instr <= hold_n;
    end
  end
  // DROP: a redirect arrived while the fetch was in flight; its response is swallowed.
  always_comb begin
    state_n = state;
    pc_n = pc;
    req_pc_n = req_pc;
    hold_n = hold_instr;
    imem_req_valid = 1'b0;
    if_valid = 1'b0;
    if_instr = NOP_INSTR;
    case (state)
      IDLE: begin
        imem_req_valid = reset || !redirect_valid;
        if (redirect_valid) pc_n = redirect_pc;
        else if (imem_req_ready) begin
          req_pc_n = pc;
          pc_n = pc + XLEN'(4);
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          state_n = imem_resp_valid ? IDLE : DROP;
        end else if (imem_resp_valid && !stall_id) begin
          if_valid = 1'b1;
          if_instr = imem_resp_instr;
          state_n = IDLE;
        end else if (imem_resp_valid) begin
          hold_n = imem_resp_instr;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          state_n = IDLE;
        end else if (!stall_id) begin
          if_valid = 1'b1;
          if_instr = hold_instr;
          state_n = IDLE;
        end
      end
      DROP: begin
        if (redirect_valid) pc_n = redirect_pc;
        if (imem_resp_valid) state_n = IDLE;
      end
    endcase
  end
  assign imem_req_addr = pc;
  assign ifid_we = !stall_id;
  assign ifid_flush = redirect_valid;
  assign if_pc = req_pc;
  assign if_pc_plus4 = req_pc + XLEN'(4);
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined core.
- Owns the PC register and issues single-outstanding requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Drives the write-enable, flush and data inputs of the IF/ID pipeline register.
- Absorbs ID-stage stalls with a one-entry hold buffer, and discards wrong-path fetches on branch/jump redirect.

Parameters:
- XLEN, 64, width of PC/data bus (matches DataBusBits).
- ILEN, 32, instruction width (matches InstrBusBits).
- RESET_PC, 64'h0, PC value after reset.
- NOP_INSTR, 32'h00000013, bubble written into IF/ID when no instruction is delivered.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_resp_valid  in  1  instruction returned (exactly one per accepted request, ≥1 cycle after accept)
- imem_resp_instr  in  ILEN  returned instruction
- stall_id  in  1  hazard unit holds IF/ID
- redirect_valid  in  1  branch/jump taken in EX
- redirect_pc  in  XLEN  target address
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID synchronous clear
- if_instr  out  ILEN  instruction to IF/ID
- if_pc  out  XLEN  PC of if_instr
- if_pc_plus4  out  XLEN  if_pc + 4
- if_valid  out  1  if_instr is a real fetched instruction (0 = bubble)

Behaviour:
- Registers:
  - pc, reset RESET_PC.
  - req_pc (PC of outstanding/held fetch), reset 0.
  - hold_instr, reset 0.
  - state, reset IDLE.
- States: IDLE, WAIT, HOLD, DROP.
- All outputs are combinational from state/inputs. Values in reset: imem_req_valid=1, imem_req_addr=RESET_PC, ifid_we=!stall_id, ifid_flush=redirect_valid, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus4=4.
- Default (no delivery): if_valid=0, if_instr=NOP_INSTR, if_pc=req_pc, if_pc_plus4=req_pc+4.
- ifid_flush = redirect_valid in every state; flush has priority over we inside IF/ID.
- ifid_we = !stall_id in every state. A non-delivery write inserts a bubble.
- IDLE:
  - imem_req_valid = !redirect_valid.
  - redirect_valid: pc<=redirect_pc, stay IDLE.
  - else valid&&ready: req_pc<=pc, pc<=pc+4, go WAIT. Not ready: hold pc, retry next cycle.
  - imem_resp_valid is ignored in IDLE (stale response after reset).
- WAIT (imem_req_valid=0):
  - redirect_valid && !resp: pc<=redirect_pc, go DROP.
  - redirect_valid && resp: discard the response, pc<=redirect_pc, go IDLE.
  - resp && !stall_id: deliver (if_valid=1, if_instr=imem_resp_instr, if_pc=req_pc), go IDLE.
  - resp && stall_id: hold_instr<=imem_resp_instr, go HOLD.
- HOLD (imem_req_valid=0):
  - redirect_valid: discard, pc<=redirect_pc, go IDLE.
  - !stall_id: deliver hold_instr with req_pc, go IDLE.
  - else stay.
- DROP (imem_req_valid=0):
  - redirect_valid: pc<=redirect_pc, stay (a later redirect wins).
  - resp: discard, go IDLE (redirect in the same cycle is still applied to pc).
- Arithmetic: pc+4 and req_pc+4 are modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is silent.
- Throughput: at most 1 instruction per 2 cycles; request issue and delivery never share a cycle.
- Latency: accept at edge N, response in cycle N+k (k≥1), instruction captured into IF/ID at the end of that cycle if not stalled.
- Reset asserted mid-WAIT/HOLD/DROP returns to IDLE at once. A response arriving after reset deasserts is dropped by the IDLE rule; the memory is reset by the same signal.
- redirect_valid and stall_id both high: flush wins, and the fetch stream restarts at redirect_pc.

Test Plan:
- **Sequential fetch:** reset, ready=1, response 1 cycle after each accept, no stall. Expect addrs 0,4,8 and ifid_we pulses with if_valid=1, if_pc=0,4,8, if_pc_plus4=4,8,12.
- **Stall hold:** assert stall_id the cycle the response 0xDEADBEEF for pc=8 arrives, for 3 cycles. Expect state HOLD, if_valid=0, ifid_we=0. On release, deliver 0xDEADBEEF with if_pc=8 in the same cycle.
- **Redirect while outstanding:** request pc=12 accepted, redirect_pc=0x100 before the response. Expect ifid_flush=1 that cycle and the later response discarded (if_valid stays 0). Next imem_req_addr=0x100.
- **Redirect coincident with response:** response and redirect_pc=0x200 in the same WAIT cycle. Expect no delivery, ifid_flush=1, next request addr 0x200.
- **Backpressure:** imem_req_ready=0 for 4 cycles in IDLE. Expect imem_req_valid=1 with addr stable, pc unchanged, bubbles (NOP_INSTR, if_valid=0) written when not stalled.
- **Async reset mid-fetch:** reset pulse in WAIT between clock edges. Expect outputs at reset values immediately; a response arriving after reset is ignored; first request addr=RESET_PC.
